uart_rx_frontend: RTL

//  Receives asynchronous 8N1 serial data on the board RX pin using 16x oversampling. Each received byte
//  is presented to the debug unit as i_uart_rx_data / i_uart_rx_flag_ready. The byte and flag are held

---
 rtl/uart_defs_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_frontend.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_defs_pkg.sv
// Definitions shared by the UART receive front end and the debug unit:
// receiver state encodings, command byte values and a baud divider helper.
package uart_defs;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'b00,
      RX_START = 2'b01,
      RX_DATA  = 2'b10,
      RX_STOP  = 2'b11
   } rx_state_t;

   // Command bytes understood by the debug unit
   localparam logic [7:0] CMD_CONT = 8'h63;
   localparam logic [7:0] CMD_STEP = 8'h73;
   localparam logic [7:0] CMD_LOAD = 8'h64;
   localparam logic [7:0] CMD_NEXT = 8'h6E;

   function automatic int calc_tick_div(input int clk_freq, input int baud_rate, input int oversample);
      return clk_freq / (baud_rate * oversample);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator: one-clock pulse every TICK_DIV clocks.
// Shared by the UART receiver and transmitter.
module uart_baud_tick #(
   parameter int TICK_DIV = 10
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign o_tick = (count == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver with 16x oversampling; holds each byte and its ready flag
// until the debug unit requests a clear.
module uart_rx_frontend
   import uart_defs::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int SIZE_TRAMA = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_rx,
   input  logic                  i_rx_reset,
   output logic                  o_rx_flag_ready,
   output logic [SIZE_TRAMA-1:0] o_rx_data,
   output logic                  o_rx_frame_error,
   output logic                  o_rx_busy
);

   localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int NW = (SIZE_TRAMA > 1) ? $clog2(SIZE_TRAMA) : 1;
   localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST = NW'(SIZE_TRAMA - 1);

   logic                  tick;
   logic                  rx_meta;
   logic                  rx_s;

   rx_state_t             state, state_n;
   logic [SW-1:0]         s_cnt, s_cnt_n;
   logic [NW-1:0]         n_cnt, n_cnt_n;
   logic [SIZE_TRAMA-1:0] shreg, shreg_n;
   logic                  armed, armed_n;
   logic [SIZE_TRAMA-1:0] data_q, data_n;
   logic                  flag_q, flag_n;
   logic                  err_q, err_n;

   uart_baud_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_baud_tick (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .o_tick  (tick)
   );

   // Two-flop synchronizer; resets to the idle line level so no false start appears.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= RX_IDLE;
         s_cnt  <= '0;
         n_cnt  <= '0;
         shreg  <= '0;
         armed  <= 1'b0;
         data_q <= '0;
         flag_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_n;
         s_cnt  <= s_cnt_n;
         n_cnt  <= n_cnt_n;
         shreg  <= shreg_n;
         armed  <= armed_n;
         data_q <= data_n;
         flag_q <= flag_n;
         err_q  <= err_n;
      end
   end

   // 'armed' records that the line was seen high in IDLE, so a held-low break
   // cannot retrigger a new frame. Clear requests are applied first so that a
   // stop-bit accept in the same clock overrides them.
   always_comb begin
      state_n = state;
      s_cnt_n = s_cnt;
      n_cnt_n = n_cnt;
      shreg_n = shreg;
      armed_n = armed;
      data_n  = data_q;
      flag_n  = flag_q;
      err_n   = err_q;

      if (i_rx_reset) begin
         flag_n = 1'b0;
         err_n  = 1'b0;
      end

      if (tick) begin
         case (state)
            RX_IDLE: begin
               if (rx_s) begin
                  armed_n = 1'b1;
               end else if (armed) begin
                  state_n = RX_START;
                  s_cnt_n = '0;
                  armed_n = 1'b0;
               end
            end
            RX_START: begin
               if (s_cnt == S_HALF) begin
                  s_cnt_n = '0;
                  if (!rx_s) begin
                     state_n = RX_DATA;
                     n_cnt_n = '0;
                  end else begin
                     state_n = RX_IDLE;
                     armed_n = 1'b1;
                  end
               end else begin
                  s_cnt_n = s_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (s_cnt == S_LAST) begin
                  shreg_n = {rx_s, shreg[SIZE_TRAMA-1:1]};
                  s_cnt_n = '0;
                  if (n_cnt == N_LAST) begin
                     state_n = RX_STOP;
                  end else begin
                     n_cnt_n = n_cnt + 1'b1;
                  end
               end else begin
                  s_cnt_n = s_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (s_cnt == S_LAST) begin
                  if (rx_s) begin
                     data_n = shreg;
                     flag_n = 1'b1;
                  end else begin
                     err_n = 1'b1;
                  end
                  state_n = RX_IDLE;
                  s_cnt_n = '0;
                  armed_n = rx_s;
               end else begin
                  s_cnt_n = s_cnt + 1'b1;
               end
            end
            default: begin
               state_n = RX_IDLE;
            end
         endcase
      end
   end

   assign o_rx_flag_ready  = flag_q;
   assign o_rx_data        = data_q;
   assign o_rx_frame_error = err_q;
   assign o_rx_busy        = (state != RX_IDLE);

endmodule
